// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: constants and
// the {pc, instr} entry format stored by the prefetch queue.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the prefetch queue: DEPTH x 64-bit register array with
// one synchronous write port and one asynchronous read port, no reset.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: buffers up to DEPTH
// {PC, instr} pairs in order and presents the oldest one to decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  input  logic [31:0]   InPC,
  input  logic [31:0]   InInstr,
  output logic          InReady,
  input  logic          Flush,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [31:0]   OutPC,
  output logic [31:0]   OutInstr,
  output logic [31:0]   OutPCPlus4,
  output logic [CW-1:0] Count
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a transfer happens on a posedge where valid && ready are both
  // high (and Flush is low); ready never depends on the partner's valid, and
  // InReady is a pure function of Count so a full queue rejects a push even
  // when decode pops in the same cycle.
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  fetch_entry_t  wdata, rdata;

  assign InReady  = (count_q != CW'(DEPTH));
  assign OutValid = (count_q != '0);
  assign Count    = count_q;

  assign push = InValid && InReady && !Flush;
  assign pop  = OutValid && OutReady && !Flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (Flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wdata.pc    = InPC;
  assign wdata.instr = InInstr;

  fetch_queue_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk_i  (Clk),
    .we_i   (push && !Reset),
    .waddr_i(wptr_q),
    .wdata_i(wdata),
    .raddr_i(rptr_q),
    .rdata_o(rdata)
  );

  // Empty queue presents a NOP at PC 0 so decode never sees stale entries.
  assign OutPC      = OutValid ? rdata.pc    : RESET_PC;
  assign OutInstr   = OutValid ? rdata.instr : NOP_INSTR;
  assign OutPCPlus4 = OutPC + PC_STEP;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, full-with-pop,
// streaming wrap-around, flush and the +4 adder wrap.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          InValid = 1'b0;
  logic [31:0]   InPC = '0;
  logic [31:0]   InInstr = '0;
  logic          InReady;
  logic          Flush = 1'b0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [31:0]   OutPC;
  logic [31:0]   OutInstr;
  logic [31:0]   OutPCPlus4;
  logic [CW-1:0] Count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .InValid   (InValid),
    .InPC      (InPC),
    .InInstr   (InInstr),
    .InReady   (InReady),
    .Flush     (Flush),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutPC     (OutPC),
    .OutInstr  (OutInstr),
    .OutPCPlus4(OutPCPlus4),
    .Count     (Count)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // one posedge, then land on the following negedge for sampling/driving
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    InValid = v;
    InPC    = pc;
    InInstr = instr;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h2000_0000 ^ pc;
  endfunction

  initial begin
    // Reset held 2 cycles with a pending push that must be ignored
    drive_in(1'b1, 32'h0000_0123, 32'hDEAD_BEEF);
    @(negedge Clk);
    step();
    step();
    check("rst_count", 32'(Count), 32'd0);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_outpc", OutPC, 32'h0);
    check("rst_outinstr", OutInstr, 32'h0);
    check("rst_pcplus4", OutPCPlus4, 32'h4);

    // Fill: push 0x0,0x4,0x8,0xC with OutReady=0
    Reset = 1'b0;
    OutReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_in(1'b1, 32'(4 * k), instr_of(32'(4 * k)));
      step();
      if (k == 0) begin
        check("first_push_valid", 32'(OutValid), 32'd1);
        check("first_push_pc", OutPC, 32'h0);
      end
    end
    check("full_count", 32'(Count), 32'd4);
    check("full_inready", 32'(InReady), 32'd0);
    // 5th push ignored
    drive_in(1'b1, 32'h10, instr_of(32'h10));
    step();
    check("overflow_count", 32'(Count), 32'd4);
    check("overflow_head", OutPC, 32'h0);

    // Drain in order
    drive_in(1'b0, 32'h0, 32'h0);
    OutReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", OutPC, 32'(4 * k));
      check("drain_instr", OutInstr, instr_of(32'(4 * k)));
      check("drain_pcplus4", OutPCPlus4, 32'(4 * k + 4));
      step();
    end
    check("drain_empty_valid", 32'(OutValid), 32'd0);
    check("drain_empty_pc", OutPC, 32'h0);
    check("drain_empty_count", 32'(Count), 32'd0);

    // Full with simultaneous pop: pop happens, push rejected
    OutReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_in(1'b1, 32'h200 + 32'(4 * k), instr_of(32'h200 + 32'(4 * k)));
      step();
    end
    drive_in(1'b1, 32'h999, instr_of(32'h999));
    OutReady = 1'b1;
    step();
    check("fullpop_count", 32'(Count), 32'd3);
    check("fullpop_head", OutPC, 32'h204);
    check("fullpop_inready", 32'(InReady), 32'd1);
    drive_in(1'b0, 32'h0, 32'h0);
    for (int k = 1; k < 4; k++) begin
      check("fullpop_drain", OutPC, 32'h200 + 32'(4 * k));
      step();
    end
    check("fullpop_empty", 32'(OutValid), 32'd0);

    // Streaming: 20 back-to-back pushes, OutReady every cycle
    OutReady = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (OutValid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", OutPC, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("stream_pc", OutPC, e);
          check("stream_instr", OutInstr, instr_of(e));
        end
      end
      check("stream_count_le1", 32'(Count <= CW'(1)), 32'd1);
      if (k < 20) begin
        drive_in(1'b1, 32'h0040_0000 + 32'(4 * k), instr_of(32'h0040_0000 + 32'(4 * k)));
        exp_q.push_back(32'h0040_0000 + 32'(4 * k));
      end else begin
        drive_in(1'b0, 32'h0, 32'h0);
      end
      step();
    end
    check("stream_all_popped", 32'(exp_q.size()), 32'd0);
    check("stream_empty", 32'(OutValid), 32'd0);

    // Flush with 3 buffered and a concurrent push/pop request
    OutReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_in(1'b1, 32'h100 + 32'(4 * k), instr_of(32'h100 + 32'(4 * k)));
      step();
    end
    check("preflush_count", 32'(Count), 32'd3);
    drive_in(1'b1, 32'h10C, instr_of(32'h10C));
    OutReady = 1'b1;
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    OutReady = 1'b0;
    check("flush_count", 32'(Count), 32'd0);
    check("flush_valid", 32'(OutValid), 32'd0);
    check("flush_pc", OutPC, 32'h0);
    check("flush_instr", OutInstr, 32'h0);
    check("flush_pcplus4", OutPCPlus4, 32'h4);
    drive_in(1'b1, 32'h500, instr_of(32'h500));
    step();
    drive_in(1'b0, 32'h0, 32'h0);
    check("postflush_valid", 32'(OutValid), 32'd1);
    check("postflush_pc", OutPC, 32'h500);
    check("postflush_count", 32'(Count), 32'd1);
    step();
    check("hold_pc", OutPC, 32'h500);
    OutReady = 1'b1;
    step();
    check("postflush_empty", 32'(OutValid), 32'd0);

    // +4 adder wraps at the top of the address space
    OutReady = 1'b0;
    drive_in(1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
    step();
    drive_in(1'b0, 32'h0, 32'h0);
    check("wrap_pc", OutPC, 32'hFFFF_FFFC);
    check("wrap_instr", OutInstr, 32'h1234_5678);
    check("wrap_pcplus4", OutPCPlus4, 32'h0);

    // Reset mid-stream discards the entry
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_valid", 32'(OutValid), 32'd0);
    check("midrst_pcplus4", OutPCPlus4, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
